// File: rtl/cmos_gate_sweep_checker_pkg.sv
// Shared types and limits for the exhaustive CMOS gate sweep checker.
package gate_sweep_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

    typedef enum logic [1:0] {
        GM_OR   = 2'd0,
        GM_NOR  = 2'd1,
        GM_AND  = 2'd2,
        GM_NAND = 2'd3
    } gate_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/cmos_gate_sweep_checker_if.sv
// Control/result bundle between a sweep requester and the gate sweep checker.
interface cmos_gate_sweep_checker_if #(
    parameter int N = 2
);
    logic         start;
    logic [1:0]   mode;
    logic         inject_en;
    logic [N-1:0] inject_idx;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic [N-1:0] first_fail;
    logic         gate_out;

    modport master (
        output start, mode, inject_en, inject_idx,
        input  busy, done, pass, err_count, first_fail, gate_out
    );

    modport slave (
        input  start, mode, inject_en, inject_idx,
        output busy, done, pass, err_count, first_fail, gate_out
    );
endinterface

// File: rtl/cmos_gate_sweep_checker_gate.sv
// Switch-level N-input NOR/NAND cells with inverted OR/AND companions.
module cmos_nway_gate #(
    parameter int N = 2
) (
    input  wire [N-1:0] a,
    output wire         nor_y,
    output wire         or_y,
    output wire         nand_y,
    output wire         and_y
);
    supply1 vdd;
    supply0 gnd;

    // Internal nodes between consecutive series devices.
    wire [N-2:0] p_chain;
    wire [N-2:0] n_chain;

    genvar i;
    generate
        for (i = 0; i < N; i = i + 1) begin : g_stage
            nmos nor_pd (nor_y, gnd, a[i]);
            pmos nand_pu (nand_y, vdd, a[i]);
            if (i == 0) begin : g_first
                pmos nor_pu (p_chain[0], vdd, a[0]);
                nmos nand_pd (n_chain[0], gnd, a[0]);
            end else if (i == N - 1) begin : g_last
                pmos nor_pu (nor_y, p_chain[i-1], a[i]);
                nmos nand_pd (nand_y, n_chain[i-1], a[i]);
            end else begin : g_mid
                pmos nor_pu (p_chain[i], p_chain[i-1], a[i]);
                nmos nand_pd (n_chain[i], n_chain[i-1], a[i]);
            end
        end
    endgenerate

    pmos or_pu (or_y, vdd, nor_y);
    nmos or_pd (or_y, gnd, nor_y);
    pmos and_pu (and_y, vdd, nand_y);
    nmos and_pd (and_y, gnd, nand_y);

endmodule

// File: rtl/cmos_gate_sweep_checker.sv
// Walks every input vector through the switch-level gate and compares it
// against a behavioural reference, reporting pass, mismatch count and first failure.
module cmos_gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cmos_gate_sweep_checker_if.slave bus
);
    generate
        if (N < N_MIN || N > N_MAX) begin : g_bad_n
            $error("cmos_gate_sweep_checker: N=%0d outside supported range", N);
        end
    endgenerate

    localparam logic [N-1:0] VEC_ZERO = {N{1'b0}};
    localparam logic [N-1:0] VEC_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] VEC_LAST = {N{1'b1}};
    localparam logic [N:0]   CNT_ZERO = {(N+1){1'b0}};
    localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};

    sweep_state_t state_r, state_nxt_s;
    gate_mode_t   mode_r;
    logic [N-1:0] vec_r, inject_idx_r, first_fail_r;
    logic [N:0]   err_count_r, err_nxt_s;
    logic         inject_en_r, pass_r, busy_r, done_r;
    logic         exp_s, gate_out_s, obs_s, mismatch_s, last_vec_s;
    wire          nor_s, or_s, nand_s, and_s;

    cmos_nway_gate #(.N(N)) u_gate (
        .a      (vec_r),
        .nor_y  (nor_s),
        .or_y   (or_s),
        .nand_y (nand_s),
        .and_y  (and_s)
    );

    // Select the switch-level output and the behavioural reference for the latched mode.
    always_comb begin
        exp_s      = 1'b0;
        gate_out_s = 1'b0;
        case (mode_r)
            GM_OR:   begin exp_s = |vec_r;  gate_out_s = or_s;   end
            GM_NOR:  begin exp_s = ~|vec_r; gate_out_s = nor_s;  end
            GM_AND:  begin exp_s = &vec_r;  gate_out_s = and_s;  end
            GM_NAND: begin exp_s = ~&vec_r; gate_out_s = nand_s; end
            default: begin exp_s = 1'b0;    gate_out_s = 1'b0;   end
        endcase
    end

    // Fault injection flips the observed value only on the chosen vector.
    always_comb begin
        obs_s      = gate_out_s ^ (inject_en_r && (vec_r == inject_idx_r));
        mismatch_s = (obs_s != exp_s);
        last_vec_s = (vec_r == VEC_LAST);
        if (mismatch_s) begin
            err_nxt_s = err_count_r + CNT_ONE;
        end else begin
            err_nxt_s = err_count_r;
        end
    end

    // Next-state logic of the sweep controller.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_DRIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE:  state_nxt_s = ST_SAMPLE;
            ST_SAMPLE: begin
                if (last_vec_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRIVE;
                end
            end
            ST_DONE:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Vector counter, latched configuration and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_r        <= VEC_ZERO;
            mode_r       <= GM_OR;
            inject_en_r  <= 1'b0;
            inject_idx_r <= VEC_ZERO;
            err_count_r  <= CNT_ZERO;
            first_fail_r <= VEC_ZERO;
            pass_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s == ST_DRIVE) || (state_nxt_s == ST_SAMPLE);
            done_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        vec_r        <= VEC_ZERO;
                        err_count_r  <= CNT_ZERO;
                        first_fail_r <= VEC_ZERO;
                        pass_r       <= 1'b0;
                        mode_r       <= gate_mode_t'(bus.mode);
                        inject_en_r  <= bus.inject_en;
                        inject_idx_r <= bus.inject_idx;
                    end
                end
                ST_SAMPLE: begin
                    err_count_r <= err_nxt_s;
                    if (mismatch_s && (err_count_r == CNT_ZERO)) begin
                        first_fail_r <= vec_r;
                    end
                    // pass must already be valid in the DONE cycle.
                    if (last_vec_s) begin
                        pass_r <= (err_nxt_s == CNT_ZERO);
                    end else begin
                        vec_r <= vec_r + VEC_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.err_count  = err_count_r;
    assign bus.first_fail = first_fail_r;
    assign bus.gate_out   = gate_out_s;

endmodule

// File: doc/cmos_gate_sweep_checker.md
# cmos_gate_sweep_checker

Self-checking exhaustive tester for a parametrised N-input CMOS gate built from switch-level pmos/nmos primitives. On `start` it walks every input vector 0 … 2^N−1 through the selected gate function (OR, NOR, AND, NAND) and compares the switch-level output against a behavioural reference. It then reports a pass flag, a mismatch count and the first failing vector. It generalises the fixed 2-input OR/NOR cell to N inputs and four functions, and adds a sweep FSM plus fault injection for bench self-test.

## Interface
- `N`, default 2: gate input count; legal 2..8.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- `mode`  in  2  gate function: 0 OR, 1 NOR, 2 AND, 3 NAND; sampled on accepted `start`.
- `inject_en`  in  1  enable fault injection; sampled on accepted `start`.
- `inject_idx`  in  N  vector whose observed output is inverted before compare; sampled on accepted `start`.
- `busy`  out  1  high during DRIVE/SAMPLE.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  1 when `err_count` == 0 at sweep end; held until next accepted `start`.
- `err_count`  out  N+1  mismatch count, range 0..2^N.
- `first_fail`  out  N  first mismatching vector; valid when `err_count` != 0.
- `gate_out`  out  1  current switch-level gate output, for waveform debug.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE → DRIVE on `start`. Clear `vec` to 0, `err_count` to 0, `first_fail` to 0, and `pass` to 0. Latch `mode`, `inject_en` and `inject_idx`.
  - DRIVE → SAMPLE unconditionally. `vec` drives the gate inputs and the gate settles.
  - SAMPLE: compare `obs = gate_out ^ (inject_en && vec == inject_idx)` with `exp`.
    - On mismatch: increment `err_count`. If `err_count` was 0, load `first_fail` with `vec`.
    - If `vec == 2^N−1`, go to DONE; otherwise increment `vec` and go to DRIVE.
  - DONE → IDLE. `done` = 1 for this cycle. `pass` = (final `err_count` == 0).
- Reference function `exp`:
  - OR = |vec, NOR = ~|vec, AND = &vec, NAND = ~&vec.
- `vec` is an N-bit counter.
  - Terminal value is detected explicitly; wrap-around never occurs inside a sweep.
- `err_count` is N+1 bits wide, so 2^N mismatches (every vector fails) cannot overflow.
- `start` in DRIVE, SAMPLE or DONE is ignored; it is not queued.
- Changes to `mode`, `inject_en` or `inject_idx` during a sweep have no effect.
- Reset (`rst_n` = 0 at a clock edge) from any state, including mid-sweep:
  - state ← IDLE; `busy` = 0, `done` = 0, `pass` = 0, `err_count` = 0, `first_fail` = 0, `vec` = 0.
- `gate_out` is combinational from the registered `vec` and latched `mode`. After reset it reflects vec = 0, mode = OR, so it is 0.

## Timing
- Accepted `start` at edge k; the first DRIVE cycle is k+1.
- Each vector takes 2 cycles, so the last SAMPLE is at cycle k+2^(N+1).
- `done` is high in cycle k+2^(N+1)+1.
  - N=2: `done` at k+9. N=8: `done` at k+513.
- `busy` is high in cycles k+1 … k+2^(N+1), and low in the DONE cycle.
- `err_count`, `first_fail` and `pass` are stable and valid in the `done` cycle. They hold until the next accepted `start`.
- The earliest back-to-back `start` is the cycle after `done`, i.e. in IDLE.

## Structure
- Package `gate_sweep_pkg`:
  - `gate_mode_t` enum (OR, NOR, AND, NAND).
  - `sweep_state_t` enum (IDLE, DRIVE, SAMPLE, DONE).
  - Constants `N_MIN` = 2 and `N_MAX` = 8.
- Sub-module `cmos_nway_gate #(N)`: the switch-level gate under test.
  - Built only from pmos/nmos primitives with supply1/supply0 rails.
  - N-input NOR: N series pmos, N parallel nmos.
  - N-input NAND: N parallel pmos, N series nmos.
  - One inverter on each to form OR and AND.
  - Output select by `mode` is done in the parent.
- Parent holds the FSM, the `vec` counter, reference compare and result registers.
- Elaboration error if N is outside N_MIN..N_MAX.

## Test plan
- N=2, mode=1 (NOR), no inject, `start` → `done` 9 cycles later, `pass`=1, `err_count`=0; `gate_out` sequence at DRIVE is 1,0,0,0.
- N=3, mode=3 (NAND), `inject_en`=1, `inject_idx`=5 → `pass`=0, `err_count`=1, `first_fail`=5, `done` at k+17.
- N=4, mode=2 (AND), `inject_en`=1, `inject_idx`=15 (terminal vector) → `err_count`=1, `first_fail`=15, no wrap and no extra vector.
- N=2, mode=0 (OR), `start` asserted again in cycles k+3 and k+8 → ignored, a single `done` at k+9; mode changed to 3 mid-sweep → result still `pass`=1.
- N=3, reset asserted at k+6 (mid-sweep) → next cycle all outputs 0, state IDLE; new `start` then completes normally with `pass`=1 at +17.
- N=8, all four modes back-to-back, no inject → each `done` 513 cycles after its `start`, `pass`=1, `err_count`=0.
